// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one MUL-class op from EX through the iterative multiplier to WB,
// with a zero/illegal fast path, a one-entry result cache, a BUSY watchdog and flush.
module mul_ctrl #(
    parameter int         TIMEOUT_CYCLES = 80,
    parameter int         CNT_W          = 7,
    parameter bit         CACHE_EN       = 1'b1,
    parameter logic [8:0] INST_MUL       = 9'h1a0,
    parameter logic [8:0] INST_MULH      = 9'h1a1,
    parameter logic [8:0] INST_MULHU     = 9'h1a3,
    parameter logic [8:0] INST_MULW      = 9'h1b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mul_valid,
    output logic        ex_mul_ready,
    input  logic [8:0]  ex_opcode,
    input  logic [63:0] ex_op1,
    input  logic [63:0] ex_op2,
    input  logic        ex_flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [63:0] wb_result,
    output logic        mul_busy,
    output logic        timeout_err,
    output logic        mult_ready,
    output logic [8:0]  mult_opcode,
    output logic [63:0] mult_op1,
    output logic [63:0] mult_op2,
    input  logic        mult_finish,
    input  logic [63:0] product_val
);
    typedef enum logic [1:0] {IDLE, BUSY, COOL, RESP} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [63:0] result, c_op1, c_op2, c_val;
    logic [8:0] c_opcode;
    logic c_valid, accept, legal, zero, hit, done, expire;
    assign ex_mul_ready = state == IDLE;
    assign wb_valid     = state == RESP;
    assign mult_ready   = state == BUSY;
    assign mul_busy     = state != IDLE;
    assign wb_result    = result;
    assign timeout_err  = expire;
    always_comb begin
        legal   = ex_opcode inside {INST_MUL, INST_MULH, INST_MULHU, INST_MULW};
        zero    = ex_op1 == '0 || ex_op2 == '0;
        hit     = CACHE_EN && c_valid && c_opcode == ex_opcode && c_op1 == ex_op1 && c_op2 == ex_op2;
        accept  = ex_mul_valid && ex_mul_ready && !ex_flush;
        done    = state == BUSY && mult_finish && !ex_flush;
        expire  = state == BUSY && !mult_finish && !ex_flush && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((!legal || zero || hit) ? RESP : BUSY) : IDLE;
            BUSY:    state_n = (done || expire) ? COOL : BUSY;
            COOL:    state_n = RESP;
            RESP:    state_n = wb_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
        if (ex_flush) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            result      <= '0;
            mult_opcode <= '0;
            mult_op1    <= '0;
            mult_op2    <= '0;
            c_valid     <= 1'b0;
            c_opcode    <= '0;
            c_op1       <= '0;
            c_op2       <= '0;
            c_val       <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == BUSY ? cnt + 1'b1 : '0;
            if (accept && (!legal || zero)) result <= '0;
            else if (accept && hit) result <= c_val;
            else if (accept) begin
                mult_opcode <= ex_opcode;
                mult_op1    <= ex_op1;
                mult_op2    <= ex_op2;
            end
            // a flushed or timed-out op never reaches the cache
            if (done) begin
                result   <= product_val;
                c_valid  <= 1'b1;
                c_opcode <= mult_opcode;
                c_op1    <= mult_op1;
                c_op2    <= mult_op2;
                c_val    <= product_val;
            end
            if (expire) result <= '0;
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed tests for mul_ctrl against a fixed-latency multiplier stub.
module tb_mul_ctrl;
    localparam logic [8:0] OP_MUL = 9'h1a0, OP_MULH = 9'h1a1, OP_MULHU = 9'h1a3, OP_MULW = 9'h1b0;
    logic clk = 0, rst = 1, ex_mul_valid = 0, ex_flush = 0, wb_ready = 0, model_en = 1;
    logic [8:0] ex_opcode = '0, mult_opcode;
    logic [63:0] ex_op1 = '0, ex_op2 = '0, wb_result, mult_op1, mult_op2, product_val;
    logic ex_mul_ready, wb_valid, mul_busy, timeout_err, mult_ready, mult_finish;
    int n_cmp = 0, n_fail = 0, lat = 3, mcnt = 0, mr_cycles = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.INST_MUL(OP_MUL), .INST_MULH(OP_MULH), .INST_MULHU(OP_MULHU), .INST_MULW(OP_MULW)) dut (
        .clk(clk), .rst(rst), .ex_mul_valid(ex_mul_valid), .ex_mul_ready(ex_mul_ready),
        .ex_opcode(ex_opcode), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_flush(ex_flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .mul_busy(mul_busy),
        .timeout_err(timeout_err), .mult_ready(mult_ready), .mult_opcode(mult_opcode),
        .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_finish(mult_finish), .product_val(product_val)
    );

    // multiplier stub: finishes on its lat-th BUSY cycle (0-based) while model_en is set
    assign mult_finish = model_en && mult_ready && mcnt == lat;
    assign product_val = mult_op1 * mult_op2;
    always @(posedge clk) begin
        mcnt      <= (mult_ready && !mult_finish) ? mcnt + 1 : 0;
        mr_cycles <= mr_cycles + int'(mult_ready);
    end

    task automatic issue(input logic [8:0] op, input logic [63:0] a, input logic [63:0] b);
        ex_opcode = op; ex_op1 = a; ex_op2 = b; ex_mul_valid = 1;
        @(negedge clk);
        ex_mul_valid = 0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 200 && !wb_valid; i++) @(negedge clk);
    endtask

    task automatic consume();
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        n_cmp++; if (ex_mul_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ex_mul_ready); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mul_busy); end
        n_cmp++; if (mult_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mult_ready: got %b want 0", mult_ready); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        n_cmp++; if (wb_result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %0h want 0", wb_result); end
        n_cmp++; if (mult_op1 !== 64'd0) begin n_fail++; $display("FAIL reset_mult_op1: got %0h want 0", mult_op1); end
    endtask

    task automatic test_mul();
        int cyc = 0;
        lat = 3;
        issue(OP_MUL, 64'd7, 64'd6);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL mul_launch: got %b want 1", mult_ready); end
        n_cmp++; if (mult_opcode !== OP_MUL) begin n_fail++; $display("FAIL mul_opcode: got %0h want %0h", mult_opcode, OP_MUL); end
        n_cmp++; if (ex_mul_ready !== 1'b0) begin n_fail++; $display("FAIL mul_ready_low: got %b want 0", ex_mul_ready); end
        while (mult_ready && cyc < 20) begin
            n_cmp++; if (mult_op1 !== 64'd7 || mult_op2 !== 64'd6) begin n_fail++; $display("FAIL mul_hold: got %0d,%0d want 7,6", mult_op1, mult_op2); end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 4", cyc); end
        n_cmp++; if (wb_valid !== 1'b0 || mul_busy !== 1'b1) begin n_fail++; $display("FAIL mul_cool: got valid=%b busy=%b want 0,1", wb_valid, mul_busy); end
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL mul_resp: got %b want 1", wb_valid); end
        n_cmp++; if (wb_result !== 64'd42) begin n_fail++; $display("FAIL mul_result: got %0d want 42", wb_result); end
        consume();
        n_cmp++; if (wb_valid !== 1'b0 || ex_mul_ready !== 1'b1) begin n_fail++; $display("FAIL mul_done: got valid=%b ready=%b want 0,1", wb_valid, ex_mul_ready); end
    endtask

    task automatic test_fast_path();
        int mr0 = mr_cycles;
        issue(OP_MUL, 64'd0, 64'h1234);
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_result !== 64'd0) begin n_fail++; $display("FAIL zero_result: got %0h want 0", wb_result); end
        consume();
        issue(9'h000, 64'd3, 64'd4);
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_result !== 64'd0) begin n_fail++; $display("FAIL illegal_result: got %0h want 0", wb_result); end
        consume();
        n_cmp++; if (mr_cycles !== mr0) begin n_fail++; $display("FAIL fast_no_launch: got %0d want %0d", mr_cycles, mr0); end
    endtask

    task automatic test_cache();
        int mr0 = mr_cycles;
        issue(OP_MUL, 64'd7, 64'd6);
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_result !== 64'd42) begin n_fail++; $display("FAIL hit_result: got %0d want 42", wb_result); end
        consume();
        n_cmp++; if (mr_cycles !== mr0) begin n_fail++; $display("FAIL hit_no_launch: got %0d want %0d", mr_cycles, mr0); end
        issue(OP_MULH, 64'd7, 64'd6);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL opcode_miss: got %b want 1", mult_ready); end
        wait_resp();
        consume();
        issue(OP_MUL, 64'd7, 64'd5);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL miss_launch: got %b want 1", mult_ready); end
        wait_resp();
        n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd35) begin n_fail++; $display("FAIL miss_result: got valid=%b %0d want 1,35", wb_valid, wb_result); end
        consume();
    endtask

    task automatic test_back_to_back();
        issue(OP_MUL, 64'd2, 64'd3);
        wait_resp();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd6 || ex_mul_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d: got valid=%b res=%0d ready=%b want 1,6,0", i, wb_valid, wb_result, ex_mul_ready);
            end
            @(negedge clk);
        end
        consume();
        issue(OP_MUL, 64'd2, 64'd3);
        n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd6) begin n_fail++; $display("FAIL b2b_hit: got valid=%b %0d want 1,6", wb_valid, wb_result); end
        consume();
    endtask

    task automatic test_flush();
        int mr0;
        lat = 20;
        issue(OP_MUL, 64'd4, 64'd5);
        repeat (4) @(negedge clk);
        ex_flush = 1;
        @(negedge clk);
        ex_flush = 0;
        n_cmp++; if (mult_ready !== 1'b0 || mul_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got mr=%b busy=%b want 0,0", mult_ready, mul_busy); end
        n_cmp++; if (ex_mul_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ex_mul_ready); end
        repeat (3) begin
            n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_wb: got %b want 0", wb_valid); end
            @(negedge clk);
        end
        mr0 = mr_cycles;
        ex_opcode = OP_MUL; ex_op1 = 64'd6; ex_op2 = 64'd7; ex_mul_valid = 1; ex_flush = 1;
        @(negedge clk);
        ex_mul_valid = 0; ex_flush = 0;
        n_cmp++; if (mul_busy !== 1'b0 || mr_cycles !== mr0) begin n_fail++; $display("FAIL flush_accept: got busy=%b mr=%0d want 0,%0d", mul_busy, mr_cycles, mr0); end
        lat = 3;
        issue(OP_MUL, 64'd3, 64'd3);
        wait_resp();
        n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd9) begin n_fail++; $display("FAIL flush_after: got valid=%b %0d want 1,9", wb_valid, wb_result); end
        consume();
        issue(OP_MUL, 64'd4, 64'd5);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL flush_no_cache: got %b want 1", mult_ready); end
        wait_resp();
        n_cmp++; if (wb_result !== 64'd20) begin n_fail++; $display("FAIL relaunch_result: got %0d want 20", wb_result); end
        consume();
    endtask

    task automatic test_timeout();
        int k = 0;
        model_en = 0;
        issue(OP_MUL, 64'd11, 64'd13);
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== 79) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 79", k); end
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_in_busy: got %b want 1", mult_ready); end
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0 || mult_ready !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_cool: got err=%b mr=%b valid=%b want 0,0,0", timeout_err, mult_ready, wb_valid);
        end
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd0) begin n_fail++; $display("FAIL timeout_result: got valid=%b %0h want 1,0", wb_valid, wb_result); end
        consume();
        model_en = 1;
        issue(OP_MUL, 64'd4, 64'd5);
        n_cmp++; if (wb_valid !== 1'b1 || wb_result !== 64'd20) begin n_fail++; $display("FAIL timeout_cache_kept: got valid=%b %0d want 1,20", wb_valid, wb_result); end
        consume();
        issue(OP_MUL, 64'd11, 64'd13);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_not_cached: got %b want 1", mult_ready); end
        wait_resp();
        n_cmp++; if (wb_result !== 64'd143) begin n_fail++; $display("FAIL post_timeout_result: got %0d want 143", wb_result); end
        consume();
    endtask

    task automatic test_reset_mid();
        lat = 20;
        issue(OP_MUL, 64'd9, 64'd9);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_cmp++; if (mult_ready !== 1'b0 || mul_busy !== 1'b0 || ex_mul_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: got mr=%b busy=%b ready=%b want 0,0,1", mult_ready, mul_busy, ex_mul_ready);
        end
        lat = 3;
        issue(OP_MUL, 64'd4, 64'd5);
        n_cmp++; if (mult_ready !== 1'b1) begin n_fail++; $display("FAIL reset_clears_cache: got %b want 1", mult_ready); end
        wait_resp();
        consume();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mul();
        test_fast_path();
        test_cache();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
